// File: rtl/mira_pkg.sv
// Shared types and defaults for the cursor-movement controller.
package mira_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    DELAY  = 2'd2,
    REPEAT = 2'd3
  } mira_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_REPEAT_DELAY    = 15;
  localparam int DEF_REPEAT_RATE     = 4;

  // Frame counter increments but sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mira_ctrl_btn_debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer for one button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic deb_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles where the synchronized input disagrees with the
  // accepted level; any agreement restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer, counter and accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/mira_ctrl.sv
// Cursor controller: debounced buttons drive a first-step / delay / auto-repeat
// FSM paced by frame ticks, emitting one-cycle step pulses with direction.
module mira_ctrl
  import mira_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic frame_tick,
  output logic step_x,
  output logic step_y,
  output logic dir_left,
  output logic dir_down,
  output logic active
);

  localparam logic [7:0] DELAY_LAST = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0] RATE_LAST  = 8'(REPEAT_RATE - 1);

  // Button index: 0 up, 1 down, 2 left, 3 right.
  logic [3:0] btn_raw, deb;
  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .btn_i (btn_raw[i]),
      .deb_o (deb[i])
    );
  end

  logic x_act, y_act, any_act;
  assign x_act   = deb[2] ^ deb[3];
  assign y_act   = deb[0] ^ deb[1];
  assign any_act = x_act | y_act;

  mira_state_e state_q, state_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        step_x_q, step_x_d, step_y_q, step_y_d;
  logic        dir_left_q, dir_left_d, dir_down_q, dir_down_d;
  logic        issue;

  // Next-state, frame counter and step issue; release beats a coincident tick.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    issue   = 1'b0;
    if (state_q != IDLE && !any_act) begin
      state_d = IDLE;
      fcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE:   if (any_act) state_d = FIRST;
        FIRST:  if (frame_tick) begin
                  issue   = 1'b1;
                  fcnt_d  = '0;
                  state_d = DELAY;
                end
        DELAY:  if (frame_tick) begin
                  if (fcnt_q == DELAY_LAST) begin
                    issue   = 1'b1;
                    fcnt_d  = '0;
                    state_d = REPEAT;
                  end else begin
                    fcnt_d = sat_inc8(fcnt_q);
                  end
                end
        REPEAT: if (frame_tick) begin
                  if (fcnt_q == RATE_LAST) begin
                    issue  = 1'b1;
                    fcnt_d = '0;
                  end else begin
                    fcnt_d = sat_inc8(fcnt_q);
                  end
                end
        default: state_d = IDLE;
      endcase
    end
    step_x_d   = issue & x_act;
    step_y_d   = issue & y_act;
    dir_left_d = issue ? deb[2] : dir_left_q;
    dir_down_d = issue ? deb[1] : dir_down_q;
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fcnt_q     <= '0;
      step_x_q   <= 1'b0;
      step_y_q   <= 1'b0;
      dir_left_q <= 1'b0;
      dir_down_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      step_x_q   <= step_x_d;
      step_y_q   <= step_y_d;
      dir_left_q <= dir_left_d;
      dir_down_q <= dir_down_d;
    end
  end

  assign step_x   = step_x_q;
  assign step_y   = step_y_q;
  assign dir_left = dir_left_q;
  assign dir_down = dir_down_q;
  assign active   = (state_q != IDLE);

endmodule

// File: tb/tb_mira_ctrl.sv
// Directed bench for mira_ctrl with short debounce and repeat timing.
module tb_mira_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
  logic frame_tick = 0;
  logic step_x, step_y, dir_left, dir_down, active;

  int checks = 0, failures = 0;
  int cyc_n, first_act, last_act;
  int xs[$], ys[$], dls[$], dds[$];

  mira_ctrl #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(3), .REPEAT_RATE(2)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .frame_tick(frame_tick),
    .step_x(step_x), .step_y(step_y), .dir_left(dir_left),
    .dir_down(dir_down), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    xs.delete(); ys.delete(); dls.delete(); dds.delete();
    first_act = -1; last_act = -1; cyc_n = 0;
  endtask

  // Advance n clocks; frame_tick is high in cycles where cyc_n % 10 == 9.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = ((cyc_n % 10) == 9);
      @(posedge clk); #1;
      if (step_x) begin xs.push_back(cyc_n); dls.push_back(int'(dir_left)); end
      if (step_y) begin ys.push_back(cyc_n); dds.push_back(int'(dir_down)); end
      if (active) begin
        if (first_act < 0) first_act = cyc_n;
        last_act = cyc_n;
      end
      cyc_n++;
    end
    frame_tick = 0;
  endtask

  task automatic do_reset();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; frame_tick = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  function automatic int qget(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  int e_right[4] = '{9, 39, 59, 79};

  initial begin
    // Reset state
    do_reset();
    chk("rst_outs", int'({step_x, step_y, dir_left, dir_down, active}), 0);

    // Short 3-cycle glitch on right must be rejected
    clr_log();
    btn_right = 1; run(3);
    btn_right = 0; run(30);
    chk("glitch_act", first_act, -1);
    chk("glitch_nx", xs.size(), 0);

    // Right held: first step at tick 9, then 3 ticks later, then every 2
    do_reset(); clr_log();
    btn_right = 1; run(85);
    chk("hold_first_act", first_act, 6);
    chk("hold_nx", xs.size(), 4);
    for (int k = 0; k < 4; k++) chk($sformatf("hold_x%0d", k), qget(xs, k), e_right[k]);
    chk("hold_ny", ys.size(), 0);
    chk("hold_dir0", qget(dls, 0), 0);

    // Up+down cancel; then left added gives x-only steps leftwards
    do_reset(); clr_log();
    btn_up = 1; btn_down = 1; run(40);
    chk("cancel_act", first_act, -1);
    chk("cancel_ny", ys.size(), 0);
    clr_log();
    btn_left = 1; run(45);
    chk("left_nx", xs.size(), 2);
    chk("left_x0", qget(xs, 0), 9);
    chk("left_x1", qget(xs, 1), 39);
    chk("left_ny", ys.size(), 0);
    chk("left_dir0", qget(dls, 0), 1);
    chk("left_dir1", qget(dls, 1), 1);

    // Down+right: both axes step together
    do_reset(); clr_log();
    btn_down = 1; btn_right = 1; run(12);
    chk("diag_x0", qget(xs, 0), 9);
    chk("diag_y0", qget(ys, 0), 9);
    chk("diag_dl", qget(dls, 0), 0);
    chk("diag_dd", qget(dds, 0), 1);

    // Release lands on the repeat tick at cycle 79: no step, IDLE next cycle
    do_reset(); clr_log();
    btn_right = 1; run(73);
    btn_right = 0; run(20);
    chk("rel_nx", xs.size(), 3);
    chk("rel_last_x", qget(xs, 2), 59);
    chk("rel_last_act", last_act, 78);

    // Async reset while a repeat step pulse is visible
    do_reset(); clr_log();
    btn_right = 1; run(60);
    chk("ar_pre_step", int'(step_x), 1);
    #2 rst = 1;
    #1 chk("ar_outs", int'({step_x, step_y, dir_left, dir_down, active}), 0);
    @(posedge clk); #1;
    rst = 0;
    clr_log();
    run(20);
    chk("ar_first_act", first_act, 6);
    chk("ar_nx", xs.size(), 1);
    chk("ar_x0", qget(xs, 0), 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mira_ctrl.md
MIRA_CTRL -- requirements
Module: mira_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the number of consecutive stable clk cycles needed to accept a button level change.
REQ-002 Parameter REPEAT_DELAY, default 15, is the number of frame ticks from the first step to the first auto-repeat step.
REQ-003 Parameter REPEAT_RATE, default 4, is the number of frame ticks between auto-repeat steps.
REQ-004 clk  input  1  system clock (pixel clock domain).
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 btn_up, btn_down, btn_left, btn_right  input  1 each  raw, asynchronous, active-high push buttons.
REQ-007 frame_tick  input  1  one-cycle pulse once per video frame, synchronous to clk.
REQ-008 step_x  output  1  one-cycle pulse; the cursor moves one column step.
REQ-009 step_y  output  1  one-cycle pulse; the cursor moves one row step.
REQ-010 dir_left  output  1  column direction qualifying step_x: 1 = column decreases, 0 = column increases.
REQ-011 dir_down  output  1  row direction qualifying step_y: 1 = row increases, 0 = row decreases.
REQ-012 active  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 Each button shall pass through a 2-FF synchronizer and then a debouncer, producing a debounced level deb_*.
REQ-014 The debounced level shall change only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any intervening bounce shall restart the count.
REQ-015 Axis activity shall be computed as x_act = deb_left XOR deb_right and y_act = deb_up XOR deb_down; opposing buttons held together shall cancel on that axis.
REQ-016 Direction shall be computed as dir_left = deb_left and dir_down = deb_down, sampled in the same cycle a step is issued.
REQ-017 Let any_act = x_act OR y_act.
REQ-018 The FSM shall have four states: IDLE, FIRST, DELAY and REPEAT, with an 8-bit frame counter fcnt.
REQ-019 IDLE shall go to FIRST when any_act = 1.
REQ-020 In FIRST, on frame_tick, the block shall issue a step, clear fcnt and go to DELAY.
REQ-021 In DELAY, on frame_tick, the block shall increment fcnt; when fcnt = REPEAT_DELAY-1 on a tick, it shall issue a step, clear fcnt and go to REPEAT.
REQ-022 In REPEAT, on frame_tick, the block shall increment fcnt; when fcnt = REPEAT_RATE-1 on a tick, it shall issue a step and clear fcnt.
REQ-023 In any non-IDLE state, any_act = 0 shall force IDLE and clear fcnt; release shall take priority over a coincident frame_tick, and no step shall be issued in that cycle.
REQ-024 "Issue a step" shall register step_x = x_act and step_y = y_act, so the pulses appear in the cycle after the triggering frame_tick edge (latency 1 clk).
REQ-025 step_x and step_y shall each be high for exactly one cycle per issued step and shall never be high while the FSM is in IDLE.
REQ-026 dir_left and dir_down shall be registered together with the step pulses and held between steps.
REQ-027 A direction change while a button remains held shall not restart the repeat timing; the new direction shall apply from the next issued step.
REQ-028 The frame counter shall saturate rather than wrap; parameter values of 1 to 255 shall be supported.

Reset
REQ-029 Asserting rst shall immediately clear the FSM to IDLE, and clear fcnt, the debounce counters, the synchronizers and all deb_* levels to 0.
REQ-030 Asserting rst shall immediately drive step_x = step_y = dir_left = dir_down = active = 0.
REQ-031 Reset asserted mid-repeat shall suppress any pending step; after reset, a held button shall require the full debounce period again.

Structure
REQ-032 A shared package shall hold the FSM state enumeration (IDLE, FIRST, DELAY, REPEAT) and the default values of DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE.
REQ-033 The synchronizer plus debouncer shall be one sub-module, btn_debounce (parameter DEBOUNCE_CYCLES), instantiated four times.
REQ-034 The FSM, the frame counter and the output registers shall reside in mira_ctrl.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=3, REPEAT_RATE=2)
REQ-035 Scenario: btn_right pulses for 3 cycles and then drops -> deb_right stays 0, active stays 0, and no steps are issued.
REQ-036 Scenario: btn_right is held, with a frame_tick every 10 clk -> exactly one step_x is issued (dir_left = 0) one cycle after the first tick following debounce; the next steps follow after 3 ticks, then every 2 ticks; step_y stays 0 throughout.
REQ-037 Scenario: btn_up and btn_down are held together -> active stays 0 and no step_y is issued; then btn_left is added -> only step_x pulses, with dir_left = 1.
REQ-038 Scenario: btn_down and btn_right are held -> step_x and step_y pulse in the same cycle, with dir_down = 1 and dir_left = 0.
REQ-039 Scenario: the button is released in the same cycle as a repeat frame_tick -> no step is issued and the FSM returns to IDLE in the next cycle.
REQ-040 Scenario: rst is asserted asynchronously mid-REPEAT, between clock edges -> all outputs go to 0 immediately; after rst is released with the button still held, the first step occurs only after a new debounce period and a new frame_tick.
